// File: rtl/daq_pkg.sv
// Shared constants and state encoding for the raw-hit readout packer.
// Markers sit above any payload value so the framer can tell them apart.
package daq_pkg;

   localparam int OUT_W  = 19;
   localparam int WCNT_W = 11;

   localparam logic [OUT_W-1:0] LY_EMPTY = 19'h01000;
   localparam logic [OUT_W-1:0] TB_EMPTY = 19'h02000;
   localparam logic [OUT_W-1:0] PAD      = 19'h03000;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_WAIT = 3'd1,
      ST_LOAD = 3'd2,
      ST_EMIT = 3'd3,
      ST_PAD  = 3'd4,
      ST_DONE = 3'd5
   } state_t;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/daq_raw_packer_if.sv
// Output word stream towards the CRC/frame stage.
// A word transfers on a clock edge where out_valid && out_ready; out_data is held while stalled.
interface daq_raw_packer_if;
   import daq_pkg::*;

   logic [OUT_W-1:0] out_data;
   logic             out_valid;
   logic             out_ready;

   modport master (output out_data, output out_valid, input out_ready);
   modport slave  (input out_data, input out_valid, output out_ready);

endinterface

// File: rtl/layer_slicer.sv
// Combinational word picker: returns word wd of layer ly from the captured time bin.
// The layer is zero-extended to a whole number of words before slicing.
module layer_slicer #(
   parameter int NLAYERS   = 6,
   parameter int LY_WIDTH  = 64,
   parameter int WORD_BITS = 12,
   parameter int LY_W      = 3,
   parameter int WD_W      = 3
) (
   input  logic [NLAYERS*LY_WIDTH-1:0] layers,
   input  logic [LY_W-1:0]             ly,
   input  logic [WD_W-1:0]             wd,
   output logic [WORD_BITS-1:0]        word
);

   localparam int NWORDS = (LY_WIDTH + WORD_BITS - 1) / WORD_BITS;

   logic [NWORDS*WORD_BITS-1:0] ext;

   always_comb begin
      ext                 = '0;
      ext[LY_WIDTH-1:0]   = layers[ly*LY_WIDTH +: LY_WIDTH];
      word                = ext[wd*WORD_BITS +: WORD_BITS];
   end

endmodule

// File: rtl/daq_raw_packer.sv
// Raw-hit readout serializer: reads one frame per time bin, slices layers into words,
// applies optional zero suppression and pads the stream to a PAD_MOD word boundary.
module daq_raw_packer
   import daq_pkg::*;
#(
   parameter int NLAYERS   = 6,
   parameter int LY_WIDTH  = 64,
   parameter int WORD_BITS = 12,
   parameter int ADDR_W    = 8,
   parameter int TBIN_W    = 5,
   parameter int PAD_MOD   = 4
) (
   input  logic                        clk,
   input  logic                        hard_rst,
   input  logic                        start,
   input  logic [ADDR_W-1:0]           start_addr,
   input  logic [TBIN_W-1:0]           tbins,
   input  logic                        zero_suppress,
   output logic                        busy,
   output logic [ADDR_W-1:0]           rd_addr,
   input  logic [NLAYERS*LY_WIDTH-1:0] rd_data,
   daq_raw_packer_if.master            out_if,
   output logic                        done,
   output logic [WCNT_W-1:0]           word_count,
   output state_t                      dbg_state
);

   localparam int NWORDS = (LY_WIDTH + WORD_BITS - 1) / WORD_BITS;
   localparam int LY_W   = (NLAYERS > 1) ? clog2(NLAYERS) : 1;
   localparam int WD_W   = (NWORDS > 1) ? clog2(NWORDS) : 1;
   localparam logic [LY_W-1:0]   LY_LAST   = LY_W'(NLAYERS - 1);
   localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(NWORDS - 1);
   localparam logic [WCNT_W-1:0] WCNT_MAX  = '1;
   localparam logic [WCNT_W-1:0] PAD_MASK  = WCNT_W'(PAD_MOD - 1);

   state_t                      state_q, state_d;
   logic [ADDR_W-1:0]           rd_addr_q, rd_addr_d;
   logic [TBIN_W-1:0]           tbins_q, tbins_d;
   logic [TBIN_W-1:0]           tb_cnt_q, tb_cnt_d;
   logic                        zs_q, zs_d;
   logic [WCNT_W-1:0]           wcnt_q, wcnt_d;
   logic [NLAYERS*LY_WIDTH-1:0] layers_q, layers_d;
   logic [NLAYERS-1:0]          ly_zero_q, ly_zero_d;
   logic                        all_zero_q, all_zero_d;
   logic [LY_W-1:0]             ly_q, ly_d;
   logic [WD_W-1:0]             wd_q, wd_d;

   logic                 out_valid, accept, pad_needed, layer_end, tbin_end;
   logic [OUT_W-1:0]     out_data;
   logic [WORD_BITS-1:0] slice_word;

   layer_slicer #(
      .NLAYERS(NLAYERS), .LY_WIDTH(LY_WIDTH), .WORD_BITS(WORD_BITS),
      .LY_W(LY_W), .WD_W(WD_W)
   ) u_slicer (
      .layers(layers_q), .ly(ly_q), .wd(wd_q), .word(slice_word)
   );

   assign accept     = out_valid && out_if.out_ready;
   assign pad_needed = (wcnt_q & PAD_MASK) != '0;

   always_ff @(posedge clk or posedge hard_rst) begin
      if (hard_rst) begin
         state_q    <= ST_IDLE;
         rd_addr_q  <= '0;
         tbins_q    <= '0;
         tb_cnt_q   <= '0;
         zs_q       <= 1'b0;
         wcnt_q     <= '0;
         layers_q   <= '0;
         ly_zero_q  <= '0;
         all_zero_q <= 1'b0;
         ly_q       <= '0;
         wd_q       <= '0;
      end else begin
         state_q    <= state_d;
         rd_addr_q  <= rd_addr_d;
         tbins_q    <= tbins_d;
         tb_cnt_q   <= tb_cnt_d;
         zs_q       <= zs_d;
         wcnt_q     <= wcnt_d;
         layers_q   <= layers_d;
         ly_zero_q  <= ly_zero_d;
         all_zero_q <= all_zero_d;
         ly_q       <= ly_d;
         wd_q       <= wd_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      rd_addr_d  = rd_addr_q;
      tbins_d    = tbins_q;
      tb_cnt_d   = tb_cnt_q;
      zs_d       = zs_q;
      wcnt_d     = wcnt_q;
      layers_d   = layers_q;
      ly_zero_d  = ly_zero_q;
      all_zero_d = all_zero_q;
      ly_d       = ly_q;
      wd_d       = wd_q;
      layer_end  = 1'b0;
      tbin_end   = 1'b0;
      // The word counter saturates so an oversized frame cannot wrap the reported length.
      if (accept && wcnt_q != WCNT_MAX) wcnt_d = wcnt_q + 11'd1;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               tbins_d   = tbins;
               zs_d      = zero_suppress;
               rd_addr_d = start_addr;
               tb_cnt_d  = '0;
               wcnt_d    = '0;
               state_d   = (tbins == '0) ? ST_PAD : ST_WAIT;
            end
         end
         ST_WAIT: state_d = ST_LOAD;
         ST_LOAD: begin
            layers_d = rd_data;
            for (int i = 0; i < NLAYERS; i++) begin
               ly_zero_d[i] = ~|rd_data[i*LY_WIDTH +: LY_WIDTH];
            end
            all_zero_d = ~|rd_data;
            ly_d       = '0;
            wd_d       = '0;
            rd_addr_d  = rd_addr_q + 1'b1;
            state_d    = ST_EMIT;
         end
         ST_EMIT: begin
            if (accept) begin
               if (zs_q && all_zero_q)             tbin_end  = 1'b1;
               else if (zs_q && ly_zero_q[ly_q])   layer_end = 1'b1;
               else if (wd_q == WD_LAST)           layer_end = 1'b1;
               else                                wd_d      = wd_q + 1'b1;
               if (layer_end) begin
                  wd_d = '0;
                  if (ly_q == LY_LAST) tbin_end = 1'b1;
                  else                 ly_d     = ly_q + 1'b1;
               end
               if (tbin_end) begin
                  tb_cnt_d = tb_cnt_q + 1'b1;
                  state_d  = (tb_cnt_d == tbins_q) ? ST_PAD : ST_WAIT;
               end
            end
         end
         ST_PAD:  if (!pad_needed) state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      out_valid = 1'b0;
      out_data  = '0;
      case (state_q)
         ST_EMIT: begin
            out_valid = 1'b1;
            if (zs_q && all_zero_q)           out_data = TB_EMPTY;
            else if (zs_q && ly_zero_q[ly_q]) out_data = LY_EMPTY;
            else                              out_data = {{(OUT_W-WORD_BITS){1'b0}}, slice_word};
         end
         ST_PAD: begin
            if (pad_needed) begin
               out_valid = 1'b1;
               out_data  = PAD;
            end
         end
         default: ;
      endcase
   end

   assign out_if.out_valid = out_valid;
   assign out_if.out_data  = out_data;
   assign busy       = (state_q == ST_WAIT) || (state_q == ST_LOAD) ||
                       (state_q == ST_EMIT) || (state_q == ST_PAD);
   assign done       = (state_q == ST_DONE);
   assign rd_addr    = rd_addr_q;
   assign word_count = wcnt_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_daq_raw_packer.sv
// Scoreboard bench for daq_raw_packer: a reference model fills exp_q at start time,
// a forked monitor pops and compares every accepted word and checks stall stability.
module tb_daq_raw_packer;
   import daq_pkg::*;

   localparam int NL = 6;
   localparam int LW = 64;
   localparam int AW = 8;
   localparam int TW = 5;

   logic           clk = 1'b0;
   logic           hard_rst = 1'b1;
   logic           start = 1'b0;
   logic [AW-1:0]  start_addr = '0;
   logic [TW-1:0]  tbins = '0;
   logic           zero_suppress = 1'b0;
   logic           busy, done;
   logic [AW-1:0]  rd_addr;
   logic [NL*LW-1:0] rd_data;
   logic [10:0]    word_count;
   state_t         dbg_state;

   daq_raw_packer_if out_if();

   daq_raw_packer #(
      .NLAYERS(NL), .LY_WIDTH(LW), .WORD_BITS(12), .ADDR_W(AW), .TBIN_W(TW), .PAD_MOD(4)
   ) dut (
      .clk(clk), .hard_rst(hard_rst), .start(start), .start_addr(start_addr),
      .tbins(tbins), .zero_suppress(zero_suppress), .busy(busy), .rd_addr(rd_addr),
      .rd_data(rd_data), .out_if(out_if), .done(done), .word_count(word_count),
      .dbg_state(dbg_state)
   );

   logic [NL*LW-1:0] mem [256];
   logic [18:0] exp_q[$];
   logic [18:0] acc_log[$];
   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   bit rdy_toggle = 1'b0;

   always #5 clk = ~clk;

   always @(posedge clk) rd_data <= mem[rd_addr];

   initial begin
      out_if.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         out_if.out_ready = rdy_toggle ? ~out_if.out_ready : 1'b1;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic sb_monitor();
      logic [18:0] exp_w;
      logic [18:0] held;
      bit pend;
      pend = 1'b0;
      held = '0;
      forever begin
         @(negedge clk);
         if (hard_rst) begin
            pend = 1'b0;
         end else begin
            if (pend) begin
               checks++;
               if (out_if.out_valid !== 1'b1 || out_if.out_data !== held) begin
                  errors++;
                  $display("FAIL stall_hold: valid=%0b data=%05h required valid=1 data=%05h",
                           out_if.out_valid, out_if.out_data, held);
               end
            end
            pend = out_if.out_valid && !out_if.out_ready;
            held = out_if.out_data;
            if (out_if.out_valid && out_if.out_ready) begin
               acc_log.push_back(out_if.out_data);
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL sb_word: got %05h required no word (queue empty)", out_if.out_data);
               end else begin
                  exp_w = exp_q.pop_front();
                  if (out_if.out_data !== exp_w) begin
                     errors++;
                     $display("FAIL sb_word: got %05h required %05h", out_if.out_data, exp_w);
                  end
               end
            end
            if (done === 1'b1) done_cnt++;
         end
      end
   endtask

   // Reference model: pushes the full expected word stream, including pad words.
   task automatic push_expected(input logic [7:0] addr, input int nt, input bit zs, output int n);
      logic [NL*LW-1:0] fr;
      logic [71:0] ext;
      n = 0;
      for (int t = 0; t < nt; t++) begin
         fr = mem[(int'(addr) + t) % 256];
         if (zs && fr == '0) begin
            exp_q.push_back(TB_EMPTY);
            n++;
         end else begin
            for (int l = 0; l < NL; l++) begin
               ext = {8'h00, fr[l*LW +: LW]};
               if (zs && ext == '0) begin
                  exp_q.push_back(LY_EMPTY);
                  n++;
               end else begin
                  for (int k = 0; k < 6; k++) begin
                     exp_q.push_back({7'b0, ext[k*12 +: 12]});
                     n++;
                  end
               end
            end
         end
      end
      while (n % 4 != 0) begin
         exp_q.push_back(PAD);
         n++;
      end
   endtask

   task automatic start_frame(input logic [7:0] addr, input logic [4:0] nt, input bit zs, output int n);
      push_expected(addr, int'(nt), zs, n);
      start_addr    = addr;
      tbins         = nt;
      zero_suppress = zs;
      start         = 1'b1;
      @(posedge clk);
      #1;
      start         = 1'b0;
      zero_suppress = ~zs;
      tbins         = nt + 5'd3;
   endtask

   task automatic wait_done(input string name, input logic [10:0] exp_wc);
      int n;
      bit seen;
      n = 0;
      seen = 1'b0;
      while (!seen && n < 2000) begin
         @(negedge clk);
         n++;
         if (done === 1'b1) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL %s_done: no done pulse within 2000 cycles, required one", name);
      end else begin
         checks++;
         if (word_count !== exp_wc) begin
            errors++;
            $display("FAIL %s_word_count: got %0d required %0d", name, word_count, exp_wc);
         end
         checks++;
         if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy_at_done: got %0b required 0", name, busy);
         end
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_drain: %0d words left required 0", name, exp_q.size());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic fill_test1(input logic [7:0] addr);
      for (int i = 0; i < NL; i++) mem[addr][i*LW +: LW] = 64'h0123_4567_89AB_CDEF << i;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || out_if.out_valid !== 1'b0 || out_if.out_data !== '0 ||
          rd_addr !== '0 || word_count !== '0 || dbg_state !== ST_IDLE) begin
         errors++;
         $display("FAIL reset_outputs: busy=%0b done=%0b valid=%0b data=%05h addr=%02h wc=%0d required all 0",
                  busy, done, out_if.out_valid, out_if.out_data, rd_addr, word_count);
      end
      @(posedge clk);
      #1;
      hard_rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_basic();
      int n;
      fill_test1(8'h10);
      start_frame(8'h10, 5'd1, 1'b0, n);
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || out_if.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_cycle1: busy=%0b valid=%0b required busy=1 valid=0", busy, out_if.out_valid);
      end
      @(negedge clk);
      checks++;
      if (out_if.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_cycle2: valid=%0b required 0", out_if.out_valid);
      end
      @(negedge clk);
      checks++;
      if (out_if.out_valid !== 1'b1 || out_if.out_data !== 19'h00DEF) begin
         errors++;
         $display("FAIL basic_first_word: valid=%0b data=%05h required valid=1 data=00def",
                  out_if.out_valid, out_if.out_data);
      end
      wait_done("basic", 11'd36);
   endtask

   task automatic test_zero_suppress();
      int n;
      mem[8'h20] = '0;
      mem[8'h21] = '0;
      mem[8'h21][3*LW +: LW] = {$urandom, $urandom} | 64'h1;
      start_frame(8'h20, 5'd2, 1'b1, n);
      checks++;
      if (exp_q[0] !== TB_EMPTY || exp_q[1] !== LY_EMPTY) begin
         errors++;
         $display("FAIL zs_model_head: got %05h %05h required 02000 01000", exp_q[0], exp_q[1]);
      end
      wait_done("zs", 11'd12);
   endtask

   task automatic test_zero_tbins();
      int n;
      int base;
      base = acc_log.size();
      start_frame(8'h55, 5'd0, 1'b0, n);
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL zero_tb_early_done: got %0b required 0", done);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || word_count !== 11'd0) begin
         errors++;
         $display("FAIL zero_tb_done: done=%0b wc=%0d required done=1 wc=0", done, word_count);
      end
      checks++;
      if (acc_log.size() != base) begin
         errors++;
         $display("FAIL zero_tb_words: got %0d words required 0", acc_log.size() - base);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_backpressure();
      int n;
      rdy_toggle = 1'b1;
      start_frame(8'h10, 5'd1, 1'b0, n);
      wait_done("bp", 11'd36);
      rdy_toggle = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_addr_wrap();
      int n;
      int cyc;
      logic [7:0] exp_a [3];
      logic [7:0] addr_log[$];
      exp_a[0] = 8'hFF;
      exp_a[1] = 8'h00;
      exp_a[2] = 8'h01;
      mem[8'hFF] = '0;
      mem[8'h00] = '0;
      mem[8'h00][2*LW +: LW] = {$urandom, $urandom} | 64'h8000;
      for (int i = 0; i < NL * LW / 32; i++) mem[8'h01][i*32 +: 32] = $urandom;
      mem[8'h01][1*LW +: LW] = '0;
      mem[8'h01][4*LW +: LW] = '0;
      for (int i = 0; i < NL * LW / 32; i++) mem[8'h02][i*32 +: 32] = $urandom;
      start_frame(8'hFF, 5'd3, 1'b1, n);
      cyc = 0;
      while (addr_log.size() < 3 && cyc < 500) begin
         @(negedge clk);
         cyc++;
         if (dbg_state == ST_LOAD) addr_log.push_back(rd_addr);
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (i >= addr_log.size()) begin
            errors++;
            $display("FAIL wrap_addr%0d: no read seen required %02h", i, exp_a[i]);
         end else if (addr_log[i] !== exp_a[i]) begin
            errors++;
            $display("FAIL wrap_addr%0d: got %02h required %02h", i, addr_log[i], exp_a[i]);
         end
      end
      wait_done("wrap", 11'(n));
   endtask

   task automatic test_reset_abort();
      int n;
      int cyc;
      int base;
      int d0;
      fill_test1(8'h30);
      base = acc_log.size();
      start_frame(8'h30, 5'd4, 1'b0, n);
      cyc = 0;
      while (acc_log.size() < base + 5 && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (acc_log.size() < base + 5) begin
         errors++;
         $display("FAIL abort_progress: got %0d words required 5", acc_log.size() - base);
      end
      start_addr = 8'h40;
      tbins      = 5'd1;
      start      = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      checks++;
      if (out_if.out_valid !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL abort_mid_emit: valid=%0b busy=%0b required 1 1", out_if.out_valid, busy);
      end
      @(posedge clk);
      #1;
      hard_rst = 1'b1;
      #1;
      checks++;
      if (out_if.out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || out_if.out_data !== '0 ||
          rd_addr !== '0 || word_count !== '0) begin
         errors++;
         $display("FAIL abort_outputs: valid=%0b busy=%0b done=%0b data=%05h addr=%02h wc=%0d required all 0",
                  out_if.out_valid, busy, done, out_if.out_data, rd_addr, word_count);
      end
      exp_q.delete();
      d0 = done_cnt;
      repeat (3) @(posedge clk);
      #1;
      hard_rst = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if (done_cnt != d0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL abort_no_done: done pulses=%0d busy=%0b required 0 0", done_cnt - d0, busy);
      end
      @(posedge clk);
      #1;
      start_frame(8'h10, 5'd1, 1'b0, n);
      wait_done("after_abort", 11'd36);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = '0;
      fork
         sb_monitor();
      join_none
      test_reset();
      test_basic();
      test_zero_suppress();
      test_zero_tbins();
      test_backpressure();
      test_addr_wrap();
      test_reset_abort();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
